// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: Intel-style multiplexed address/data bus-cycle generator for an
// external real-time-clock chip. Each accepted start runs one complete transaction
// (address phase, then a write or read data phase) and ends with a one-cycle done.
//
// Optional feature macro: RTC_BUS_GAP_EN
//   defined   -> a GAP state of T_GAP idle cycles follows DONE (chip recovery time)
//   undefined -> DONE returns straight to IDLE
//
// Parameters:
//   T_PH   clock cycles per bus phase (>= 2)
//   T_GAP  idle cycles after each transaction (>= 1, gap build only)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             request a transaction (sampled only in IDLE)
//   rw_i                1 = read, 0 = write (sampled with start_i)
//   addr_i, wdata_i     register address and write byte (sampled with start_i)
//   busy_o              transaction in progress
//   done_o              one-cycle completion pulse
//   rdata_o             last byte read, held until the next read completes
//   cs_n_o, rd_n_o, wr_n_o, a_d_n_o  active-low chip strobes (a_d_n_o = 0: address)
//   ad_out_o, ad_oe_o   bus drive value and its tristate enable
//   ad_in_i             bus value from the pad
module rtc_bus_cycle #(
    parameter int unsigned T_PH  = 10,
    parameter int unsigned T_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       a_d_n_o,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    input  logic [7:0] ad_in_i
);

    // One counter serves every timed state; sized for the longer of the two loads.
    localparam int unsigned CntMax = (T_PH > T_GAP) ? T_PH : T_GAP;
    localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] PhLoad = CntW'(T_PH - 1);
`ifdef RTC_BUS_GAP_EN
    localparam logic [CntW-1:0] GapLoad = CntW'(T_GAP - 1);
`endif

`ifdef RTC_BUS_GAP_EN
    typedef enum logic [2:0] {
        StIdle, StAAct, StARel, StDAct, StDRel, StDone, StGap
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StAAct, StARel, StDAct, StDRel, StDone
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cs_n_q, cs_n_d;
    logic            rd_n_q, rd_n_d;
    logic            wr_n_q, wr_n_d;
    logic            a_d_n_q, a_d_n_d;
    logic [7:0]      ad_out_q, ad_out_d;
    logic            ad_oe_q, ad_oe_d;

    logic            ph_end;

    assign ph_end = (cnt_q == '0);

    // Next-state, phase counter and latched transaction fields.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StAAct;
                    cnt_d   = PhLoad;
                    rw_d    = rw_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            StAAct, StARel, StDAct, StDRel: begin
                if (ph_end) begin
                    cnt_d = PhLoad;
                    unique case (state_q)
                        StAAct:  state_d = StARel;
                        StARel:  state_d = StDAct;
                        StDAct:  state_d = StDRel;
                        default: state_d = StDone;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                // Capture on the last D_ACT cycle, while rd_n is still low.
                if (state_q == StDAct && ph_end && rw_q) begin
                    rdata_d = ad_in_i;
                end
            end
            StDone: begin
`ifdef RTC_BUS_GAP_EN
                state_d = StGap;
                cnt_d   = GapLoad;
`else
                state_d = StIdle;
`endif
            end
`ifdef RTC_BUS_GAP_EN
            StGap: begin
                if (ph_end) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are decoded from the state being entered, then registered, so
    // every strobe comes straight from a flop.
    always_comb begin
        busy_d   = (state_d != StIdle);
        done_d   = 1'b0;
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_n_d  = 1'b1;
        ad_out_d = 8'h00;
        ad_oe_d  = 1'b0;
        unique case (state_d)
            StAAct: begin
                cs_n_d   = 1'b0;
                a_d_n_d  = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            StARel: begin
                // Address hold time after the strobes rise.
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            StDAct: begin
                cs_n_d = 1'b0;
                if (rw_d) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            StDRel: begin
                if (!rw_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            rdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_n_q  <= 1'b1;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_n_q  <= a_d_n_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign cs_n_o   = cs_n_q;
    assign rd_n_o   = rd_n_q;
    assign wr_n_o   = wr_n_q;
    assign a_d_n_o  = a_d_n_q;
    assign ad_out_o = ad_out_q;
    assign ad_oe_o  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: two instances (T_PH = 10 and T_PH = 2) share one stimulus
// stream. A transaction-level model predicts every output from the start cycle and
// the phase arithmetic; directed sequences pin the model with literal expectations,
// then a randomized phase exercises starts, reads, writes and resets.
module tb_rtc_bus_cycle;

    localparam int unsigned TGap = 4;
`ifdef RTC_BUS_GAP_EN
    localparam int G = TGap;
`else
    localparam int G = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;

    logic       busy   [2];
    logic       done   [2];
    logic [7:0] rdata  [2];
    logic       cs_n   [2];
    logic       rd_n   [2];
    logic       wr_n   [2];
    logic       a_d_n  [2];
    logic [7:0] ad_out [2];
    logic       ad_oe  [2];

    int tph [2] = '{10, 2};

    always #5 clk = ~clk;

    rtc_bus_cycle #(.T_PH(10), .T_GAP(TGap)) u_dut10 (
        .clk(clk), .rst(rst), .start_i(start), .rw_i(rw), .addr_i(addr),
        .wdata_i(wdata), .busy_o(busy[0]), .done_o(done[0]), .rdata_o(rdata[0]),
        .cs_n_o(cs_n[0]), .rd_n_o(rd_n[0]), .wr_n_o(wr_n[0]), .a_d_n_o(a_d_n[0]),
        .ad_out_o(ad_out[0]), .ad_oe_o(ad_oe[0]), .ad_in_i(ad_in)
    );

    rtc_bus_cycle #(.T_PH(2), .T_GAP(TGap)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start), .rw_i(rw), .addr_i(addr),
        .wdata_i(wdata), .busy_o(busy[1]), .done_o(done[1]), .rdata_o(rdata[1]),
        .cs_n_o(cs_n[1]), .rd_n_o(rd_n[1]), .wr_n_o(wr_n[1]), .a_d_n_o(a_d_n[1]),
        .ad_out_o(ad_out[1]), .ad_oe_o(ad_oe[1]), .ad_in_i(ad_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: cycle index advances at every posedge; a transaction whose
    // start was sampled at the end of cycle s occupies cycles s+1 .. s+1+4*T+G.
    int         cyc = 0;
    bit         m_act   [2] = '{0, 0};
    int         m_s     [2] = '{0, 0};
    logic       m_rw    [2] = '{0, 0};
    logic [7:0] m_addr  [2] = '{0, 0};
    logic [7:0] m_wdata [2] = '{0, 0};
    logic [7:0] m_rdata [2] = '{0, 0};

    function automatic int m_end(input int i);
        return m_s[i] + 1 + 4 * tph[i] + G;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i]   <= 1'b0;
                m_rdata[i] <= 8'h00;
            end else begin
                if (m_act[i] && m_rw[i] && cyc == m_s[i] + 3 * tph[i]) m_rdata[i] <= ad_in;
                if ((!m_act[i] || cyc > m_end(i)) && start) begin
                    m_act[i]   <= 1'b1;
                    m_s[i]     <= cyc;
                    m_rw[i]    <= rw;
                    m_addr[i]  <= addr;
                    m_wdata[i] <= wdata;
                end
            end
        end
        cyc <= cyc + 1;
    end

    // {busy, done, cs_n, rd_n, wr_n, a_d_n, ad_oe, ad_out, rdata}
    function automatic logic [22:0] model_out(input int i);
        logic       b, d, cs, rd, wr, ad, oe;
        logic [7:0] o8;
        int         o, ph, t;
        t = tph[i];
        b = 0; d = 0; cs = 1; rd = 1; wr = 1; ad = 1; oe = 0; o8 = 8'h00;
        if (m_act[i] && cyc <= m_end(i)) begin
            b = 1;
            o = cyc - m_s[i];
            if (o <= 4 * t) begin
                ph = (o - 1) / t;
                case (ph)
                    0: begin cs = 0; ad = 0; wr = 0; oe = 1; o8 = m_addr[i]; end
                    1: begin oe = 1; o8 = m_addr[i]; end
                    2: begin
                        cs = 0;
                        if (m_rw[i]) rd = 0;
                        else begin wr = 0; oe = 1; o8 = m_wdata[i]; end
                    end
                    default: if (!m_rw[i]) begin oe = 1; o8 = m_wdata[i]; end
                endcase
            end else if (o == 4 * t + 1) begin
                d = 1;
            end
        end
        return {b, d, cs, rd, wr, ad, oe, o8, m_rdata[i]};
    endfunction

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("T_PH=%0d outputs at cycle %0d", tph[i], cyc),
                  {9'd0, busy[i], done[i], cs_n[i], rd_n[i], wr_n[i], a_d_n[i], ad_oe[i],
                   ad_out[i], rdata[i]},
                  {9'd0, model_out(i)});
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int s;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset strobes", {cs_n[0], rd_n[0], wr_n[0], a_d_n[0]}, 4'hF);
        check("reset busy/oe/rdata", {busy[0], ad_oe[0], rdata[0]}, 10'h000);

        // Write 0x45 to 0x21, with a stray start during the transaction.
        s = cyc; start = 1; rw = 0; addr = 8'h21; wdata = 8'h45;
        wait_to(s + 1); start = 0;
        check("wr A_ACT strobes", {cs_n[0], wr_n[0], a_d_n[0], rd_n[0]}, 4'b0001);
        check("wr A_ACT ad_out", ad_out[0], 8'h21);
        check("wr A_ACT busy", busy[0], 1'b1);
        wait_to(s + 9);
        check("T_PH=2 wr done", done[1], 1'b1);
        wait_to(s + 10);
        check("wr A_ACT last cs_n", cs_n[0], 1'b0);
        wait_to(s + 11);
        check("wr A_REL strobes/ad", {cs_n[0], a_d_n[0], ad_oe[0], ad_out[0]}, 11'h721);
        wait_to(s + 15); start = 1; rw = 1; addr = 8'h7e;
        wait_to(s + 16); start = 0;
        wait_to(s + 21);
        check("wr D_ACT strobes", {cs_n[0], wr_n[0], a_d_n[0], rd_n[0]}, 4'b0011);
        check("wr D_ACT ad_out", ad_out[0], 8'h45);
        wait_to(s + 31);
        check("wr D_REL wr_n", {wr_n[0], ad_oe[0], ad_out[0]}, 10'h345);
        wait_to(s + 40);
        check("wr no early done", done[0], 1'b0);
        wait_to(s + 41);
        check("wr done", {done[0], busy[0]}, 2'b11);
        wait_to(s + 42);
        check("wr done ends", {done[0], busy[0]}, {1'b0, G != 0});
        wait_to(s + 46);

        // Read of 0x22 with 0x59 on the bus.
        s = cyc; start = 1; rw = 1; addr = 8'h22; ad_in = 8'h59;
        wait_to(s + 1); start = 0;
        wait_to(s + 9);
        check("T_PH=2 rd done/rdata", {done[1], rdata[1]}, 9'h159);
        wait_to(s + 21);
        check("rd D_ACT", {rd_n[0], wr_n[0], ad_oe[0], cs_n[0]}, 4'b0100);
        wait_to(s + 41);
        check("rd done/rdata", {done[0], rdata[0]}, 9'h159);
        wait_to(s + 46);

        // Back-to-back: start held high.
        s = cyc; start = 1; rw = 0; addr = 8'h33; wdata = 8'h44;
        wait_to(s + 41);
        check("b2b first done", done[0], 1'b1);
        wait_to(s + 82 + G);
        check("b2b no early second done", done[0], 1'b0);
        wait_to(s + 83 + G);
        check("b2b second done", done[0], 1'b1);
        start = 0;
        wait_to(s + 83 + G + 46);

        // Reset in the middle of the write data phase.
        s = cyc; start = 1; rw = 0; addr = 8'h10; wdata = 8'haa;
        wait_to(s + 1); start = 0;
        wait_to(s + 25);
        check("pre-reset wr_n low", wr_n[0], 1'b0);
        rst = 1;
        #1;
        check("async reset strobes", {cs_n[0], rd_n[0], wr_n[0], a_d_n[0]}, 4'hF);
        check("async reset oe/busy/done", {ad_oe[0], busy[0], done[0], ad_out[0]}, 11'h000);
        @(negedge clk); rst = 0;
        wait_to(s + 41);
        check("aborted no done", {done[0], busy[0]}, 2'b00);

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            rw    = $urandom_range(0, 1) != 0;
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            ad_in = 8'($urandom);
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        start = 0; rst = 0;
        repeat (60) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle generator between the RTC control FSM and the external real-time-clock chip's multiplexed address/data bus. Each `start` strobe from the controller runs one complete Intel-style transaction (address phase, then data-write or data-read phase) on `cs_n`/`rd_n`/`wr_n`/`a_d_n`/`ad`, and reports completion with a one-cycle `done` pulse. For reads, the captured byte is returned on `rdata`. The controller's write-complete and read-complete inputs are driven from `done`.

## Interface
- `T_PH`, 10: clock cycles per bus phase. Minimum 2. 10 gives 100 ns at 100 MHz.
- `T_GAP`, 4: idle cycles enforced after each transaction. Used only when the gap feature is compiled in.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transaction. Sampled only in IDLE.
- `rw` in 1: transaction direction, 1 = read, 0 = write. Sampled with `start`.
- `addr` in 8: RTC register address. Sampled with `start`.
- `wdata` in 8: write byte. Sampled with `start`.
- `busy` out 1: high from the cycle after `start` is accepted through the last cycle before returning to IDLE.
- `done` out 1: one-cycle pulse at transaction end.
- `rdata` out 8: last byte read. Held until the next read completes.
- `cs_n`, `rd_n`, `wr_n`, `a_d_n` out 1 each: RTC strobes, active-low. `a_d_n` = 0 selects address.
- `ad_out` out 8: bus drive value.
- `ad_oe` out 1: tristate enable for `ad_out`, active-high. The pad tristate lives at top level.
- `ad_in` in 8: bus input from the pad.

## Operation
- FSM states: IDLE, A_ACT, A_REL, D_ACT, D_REL, DONE, plus GAP when the gap feature is compiled in.
- One phase counter is loaded with `T_PH-1` on entry to each timed state. It decrements each cycle. The state advances when the counter is 0.
- **IDLE**
  - All strobes high. `ad_oe`=0.
  - If `start`=1: latch `rw`, `addr`, `wdata`, then go to A_ACT.
- **A_ACT**
  - `cs_n`=0, `a_d_n`=0, `wr_n`=0.
  - `ad_oe`=1, `ad_out`=addr.
- **A_REL**
  - `cs_n`=`wr_n`=1, `a_d_n`=1.
  - `ad_oe`=1 and `ad_out`=addr, held for address hold time.
- **D_ACT**
  - `cs_n`=0, `a_d_n`=1.
  - Write: `wr_n`=0, `ad_oe`=1, `ad_out`=wdata.
  - Read: `rd_n`=0, `ad_oe`=0.
  - On a read, `rdata` is loaded from `ad_in` on the last D_ACT cycle (counter=0). This samples before `rd_n` rises.
- **D_REL**
  - Strobes high.
  - Write: `ad_oe`=1 holding wdata.
  - Read: `ad_oe`=0.
- **DONE**
  - `done`=1 for exactly one cycle.
  - Next state: IDLE, or GAP when the gap feature is compiled in.
- `start` while not in IDLE is ignored. It is not queued.
- `busy` = (state != IDLE).
- Strobe outputs are registered, so there are no glitches. At most one of `rd_n`/`wr_n` is low at any time.
- Reset at any point, including mid-cycle:
  - State goes to IDLE immediately.
  - Strobes: `cs_n`=`rd_n`=`wr_n`=`a_d_n`=1.
  - `ad_oe`=0, `ad_out`=0, `rdata`=0, `done`=0, `busy`=0.
  - No `done` is produced for the aborted transaction.

## Timing
- `start` sampled at edge k, in IDLE. A_ACT outputs are visible after edge k+1.
- Each timed state lasts exactly `T_PH` cycles.
- `done` is high in cycle k+1+4·`T_PH`.
- `busy` falls one cycle after `done`.
- Back-to-back transactions, without the gap feature: next `start` is accepted at the cycle after `done`. Minimum period is 4·`T_PH`+2 cycles.
- `rdata` is valid from the `done` cycle onward.

## Configuration
- Macro: `RTC_BUS_GAP_EN`.
- **Defined:** DONE → GAP.
  - GAP holds all strobes high and `ad_oe`=0 for `T_GAP` cycles, then goes to IDLE.
  - `busy` stays high through GAP.
  - This satisfies the chip's inter-access recovery time.
- **Undefined:** the GAP state and its counter logic are absent. DONE → IDLE directly.

## Test plan
- Write, `T_PH`=10, addr=0x21, wdata=0x45, `start` at cycle 0:
  - `cs_n`/`wr_n`/`a_d_n` low for cycles 1–10 with `ad_out`=0x21.
  - `wr_n` low with `ad_out`=0x45 for cycles 21–30.
  - `done` pulse at cycle 41. `rd_n` never low.
- Read, addr=0x22, bench drives `ad_in`=0x59 during D_ACT:
  - `ad_oe`=0 and `rd_n`=0 for cycles 21–30.
  - `rdata`=0x59 at `done`, cycle 41.
- `start` pulsed at cycle 15 during a transaction: ignored. Exactly one `done`, at cycle 41.
- Back-to-back: `start` asserted the cycle after `done` is accepted. Second `done` 4·`T_PH`+1 cycles later. With `RTC_BUS_GAP_EN` and `T_GAP`=4, acceptance is delayed 4 cycles.
- `rst` at cycle 25, mid-D_ACT write:
  - Strobes high and `ad_oe`=0 immediately.
  - No `done`. `busy`=0.
  - A new `start` after reset completes normally.
- `T_PH`=2 corner: full write-then-read completes with `done` at cycle 9 each. Strobe pulse widths are exactly 2 cycles.
